// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: synchronizer chain, debounce filter, edge pulses.
// Optional long-press detection is enabled by defining BUTTON_CONDITIONER_LONGPRESS_EN.
module button_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] rawIn,
  output logic [NUM_CH-1:0] levelOut,
  output logic [NUM_CH-1:0] risePulse,
  output logic [NUM_CH-1:0] fallPulse,
  output logic [NUM_CH-1:0] longPress
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("button_conditioner: NUM_CH must be in 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_conditioner: HOLD_CYCLES must be at least 1");
  end

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]     cnt_q  [NUM_CH];
  logic [CW-1:0]     cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [NUM_CH-1:0] long_q, long_d;

  always_comb begin
    sync_d[0] = rawIn;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // A change is accepted on the DEBOUNCE_CYCLES-th consecutive mismatch.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[SYNC_STAGES-1][i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
          rise_d[i]  = ~level_q[i];
          fall_d[i]  = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      long_q  <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q [NUM_CH];
  logic [HW-1:0] hold_d [NUM_CH];

  // Saturating at HOLD_CYCLES guarantees a single pulse per press.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_d[i] = '0;
      if (level_q[i]) begin
        hold_d[i] = hold_q[i];
        if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
        long_d[i] = (hold_q[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end
`else
  always_comb begin
    long_d = '0;
  end
`endif

  assign levelOut  = level_q;
  assign risePulse = rise_q;
  assign fallPulse = fall_q;
  assign longPress = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner (NUM_CH=4, SYNC=2, DEBOUNCE=4, HOLD=10).
module tb_button_conditioner;

  logic       clock;
  logic       reset;
  logic [3:0] rawIn;
  logic [3:0] levelOut, risePulse, fallPulse, longPress;

  button_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset), .rawIn(rawIn),
    .levelOut(levelOut), .risePulse(risePulse),
    .fallPulse(fallPulse), .longPress(longPress)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_chk  = 0;

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif

  task automatic add(input logic rst, input logic [3:0] raw, input logic [3:0] lvl,
                     input logic [3:0] rise, input logic [3:0] fall, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.lvl = lvl; v.rise = rise; v.fall = fall; v.lng = 4'h0;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @vec %0d: got %h expected %h", name, idx, act, exp);
  endtask

  initial begin
    reset = 1'b1;
    rawIn = 4'h0;

    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 3);  // 0-2   reset with inputs high
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 5);  // 3-7
    add(0, 4'hF, 4'hF, 4'hF, 4'h0, 1);  // 8     accepted 5 edges after first non-reset edge
    add(0, 4'hF, 4'hF, 4'h0, 4'h0, 2);  // 9-10
    add(0, 4'h0, 4'hF, 4'h0, 4'h0, 5);  // 11-15
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 1);  // 16
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 2);  // 17-18
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 5);  // 19-23 clean rise ch0
    add(0, 4'h1, 4'h1, 4'h1, 4'h0, 1);  // 24
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 2);  // 25-26
    add(0, 4'h3, 4'h1, 4'h0, 4'h0, 3);  // 27-29 bounce ch1
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 1);  // 30
    add(0, 4'h3, 4'h1, 4'h0, 4'h0, 3);  // 31-33
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 6);  // 34-39
    add(0, 4'hD, 4'h1, 4'h0, 4'h0, 5);  // 40-44 raise ch2,ch3
    add(0, 4'hD, 4'hD, 4'hC, 4'h0, 1);  // 45
    add(0, 4'hD, 4'hD, 4'h0, 4'h0, 2);  // 46-47
    add(0, 4'h1, 4'hD, 4'h0, 4'h0, 5);  // 48-52 concurrent fall
    add(0, 4'h1, 4'h1, 4'h0, 4'hC, 1);  // 53
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 2);  // 54-55
    add(0, 4'h0, 4'h1, 4'h0, 4'h0, 5);  // 56-60
    add(0, 4'h0, 4'h0, 4'h0, 4'h1, 1);  // 61
    add(0, 4'h0, 4'h0, 4'h0, 4'h0, 2);  // 62-63
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 3);  // 64-66 rise, then reset mid-count
    add(1, 4'h1, 4'h0, 4'h0, 4'h0, 1);  // 67
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 5);  // 68-72
    add(0, 4'h1, 4'h1, 4'h1, 4'h0, 1);  // 73
    add(0, 4'h1, 4'h1, 4'h0, 4'h0, 22); // 74-95 held: long press, no repeat

    // ch0 level rises at edges 24 and 73; long press ten edges later.
    vecs[34].lng = {3'b000, LP};
    vecs[83].lng = {3'b000, LP};

    @(posedge clock);
    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].rst;
      rawIn = vecs[i].raw;
      @(posedge clock);
      #1;
      check("levelOut",  i, levelOut,  vecs[i].lvl);
      check("risePulse", i, risePulse, vecs[i].rise);
      check("fallPulse", i, fallPulse, vecs[i].fall);
      check("longPress", i, longPress, vecs[i].lng);
      check("rise_and_fall", i, risePulse & fallPulse, 4'h0);
    end

    // Reset while levelOut is high clears everything at that edge.
    @(negedge clock);
    reset = 1'b1;
    rawIn = 4'hF;
    @(posedge clock);
    #1;
    check("rst_level", 0, levelOut, 4'h0);
    check("rst_pulses", 0, risePulse | fallPulse | longPress, 4'h0);

    // Short high burst after release never gets accepted.
    @(negedge clock);
    reset = 1'b0;
    rawIn = 4'h6;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("burst_level", k, levelOut, 4'h0);
    end
    @(negedge clock);
    rawIn = 4'h0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      check("burst_quiet", k, levelOut | risePulse | fallPulse, 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
